// File: rtl/johnson_decoder_pkg.sv
// Shared constants and FSM encoding for the Johnson-counter receive decoder.
package johnson_decoder_pkg;

  localparam int N_DEF   = 5;
  localparam int SEQ_LEN = 2 * N_DEF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson state word -> {legal, index}; no state, zero latency.
module johnson_code_decode
  import johnson_decoder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] idx
);

  int ones;
  int edges;

  // A legal word has at most one 0/1 boundary when read from bit N-1 to bit 0.
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < N; i++) begin
      ones += int'(code[i]);
    end
    for (int i = 0; i < N - 1; i++) begin
      edges += int'(code[i] ^ code[i+1]);
    end
    legal = (edges <= 1);
    idx   = code[0] ? IW'(2 * N - ones) : IW'(ones);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Decodes sampled Johnson codes, checks sequence progress, tracks lock and errors.
// All outputs register one cycle after code_valid; no backpressure.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int IW         = $clog2(SEQ_LEN),
  parameter int LOCK_COUNT = 3,
  parameter int EW         = 8
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic [N-1:0]  code,
  input  logic          code_valid,
  output logic [IW-1:0] index,
  output logic          index_valid,
  output logic          locked,
  output logic          wrap,
  output logic          err,
  output logic [EW-1:0] err_count
);

  localparam int              MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(2 * N - 1);
  localparam logic [MW-1:0]   MATCH_TOP = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0]   ERR_MAX   = '1;

  logic          code_legal;
  logic [IW-1:0] code_idx;
  logic [IW-1:0] succ_idx_d;
  logic          is_succ;
  logic          is_hold;
  logic          is_wrap;

  state_e        state_q;
  logic [IW-1:0] index_q;
  logic          index_valid_q;
  logic          locked_q;
  logic          wrap_q;
  logic          err_q;
  logic [EW-1:0] err_count_q;
  logic [MW-1:0] match_q;

  johnson_code_decode #(
    .N  (N),
    .IW (IW)
  ) u_code_decode (
    .code  (code),
    .legal (code_legal),
    .idx   (code_idx)
  );

  assign succ_idx_d = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
  assign is_succ    = code_legal && (code_idx == succ_idx_d);
  assign is_hold    = code_legal && (code_idx == index_q);
  assign is_wrap    = is_succ && (index_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q       <= ST_UNLOCKED;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      wrap_q        <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      match_q       <= '0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (code_valid) begin
        case (state_q)
          ST_UNLOCKED: begin
            if (code_legal) begin
              index_q       <= code_idx;
              index_valid_q <= 1'b1;
              match_q       <= '0;
              state_q       <= ST_ACQUIRE;
            end else begin
              index_valid_q <= 1'b0;
            end
          end
          ST_ACQUIRE: begin
            if (!code_legal) begin
              index_valid_q <= 1'b0;
              state_q       <= ST_UNLOCKED;
            end else if (is_succ) begin
              index_q <= code_idx;
              wrap_q  <= is_wrap;
              if (match_q == MATCH_TOP) begin
                match_q  <= '0;
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                match_q <= match_q + MW'(1);
              end
            end else if (!is_hold) begin
              // Legal jump while acquiring: restart the count from the new position.
              index_q <= code_idx;
              match_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (is_succ || is_hold) begin
              index_q <= code_idx;
              wrap_q  <= is_wrap;
            end else begin
              err_q    <= 1'b1;
              state_q  <= ST_UNLOCKED;
              locked_q <= 1'b0;
              if (err_count_q != ERR_MAX) begin
                err_count_q <= err_count_q + EW'(1);
              end
              if (code_legal) begin
                index_q <= code_idx;
              end else begin
                index_valid_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign locked      = locked_q;
  assign wrap        = wrap_q;
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench: directed vector table, error-counter saturation, random traffic vs model.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [4:0] code;
  logic       code_valid;
  logic [3:0] index;
  logic       index_valid;
  logic       locked;
  logic       wrap;
  logic       err;
  logic [7:0] err_count;

  johnson_decoder dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .code        (code),
    .code_valid  (code_valid),
    .index       (index),
    .index_valid (index_valid),
    .locked      (locked),
    .wrap        (wrap),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr_n;
    logic       vld;
    logic [4:0] code;
    int         e_idx;
    int         e_iv;
    int         e_lk;
    int         e_wr;
    int         e_er;
    int         e_ec;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] seq[10];
  int         checks = 0;
  int         errors = 0;

  // Reference model: position found by searching the generated ring sequence.
  int m_state, m_idx, m_iv, m_match, m_wr, m_er, m_ec;

  function automatic int find_pos(input logic [4:0] c);
    for (int k = 0; k < 10; k++) if (seq[k] == c) return k;
    return -1;
  endfunction

  task automatic model_step(input logic clr_n_i, input logic vld_i, input logic [4:0] c);
    int p;
    int nxt;
    p   = find_pos(c);
    nxt = (m_idx + 1) % 10;
    m_wr = 0;
    m_er = 0;
    if (!clr_n_i) begin
      m_state = 0; m_idx = 0; m_iv = 0; m_match = 0; m_ec = 0;
    end else if (vld_i) begin
      if (m_state == 0) begin
        if (p >= 0) begin m_idx = p; m_iv = 1; m_match = 0; m_state = 1; end
        else m_iv = 0;
      end else if (m_state == 1) begin
        if (p < 0) begin m_iv = 0; m_state = 0; end
        else if (p == nxt) begin
          m_wr = (m_idx == 9); m_idx = p; m_match++;
          if (m_match == 3) begin m_state = 2; m_match = 0; end
        end else if (p != m_idx) begin m_idx = p; m_match = 0; end
      end else begin
        if (p >= 0 && (p == nxt || p == m_idx)) begin
          m_wr = (p == nxt && m_idx == 9); m_idx = p;
        end else begin
          m_er = 1;
          if (m_ec < 255) m_ec++;
          if (p >= 0) m_idx = p; else m_iv = 0;
          m_state = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic clr_n_i, input logic vld_i, input logic [4:0] c);
    clear_n    = clr_n_i;
    code_valid = vld_i;
    code       = c;
    @(posedge clk);
    #1;
    model_step(clr_n_i, vld_i, c);
    chk("model_index",       int'(index),       m_idx);
    chk("model_index_valid", int'(index_valid), m_iv);
    chk("model_locked",      int'(locked),      int'(m_state == 2));
    chk("model_wrap",        int'(wrap),        m_wr);
    chk("model_err",         int'(err),         m_er);
    chk("model_err_count",   int'(err_count),   m_ec);
  endtask

  task automatic add(input logic cl, input logic v, input logic [4:0] c, input int ei,
                     input int eiv, input int elk, input int ewr, input int eer, input int eec);
    vec_t t;
    t.clr_n = cl; t.vld = v; t.code = c; t.e_idx = ei; t.e_iv = eiv;
    t.e_lk = elk; t.e_wr = ewr; t.e_er = eer; t.e_ec = eec;
    tbl.push_back(t);
  endtask

  initial begin
    logic [4:0] s;
    logic [4:0] c;
    int         r;
    s = '0;
    for (int k = 0; k < 10; k++) begin
      seq[k] = s;
      s = {~s[0], s[4:1]};
    end
    m_state = 0; m_idx = 0; m_iv = 0; m_match = 0; m_ec = 0; m_wr = 0; m_er = 0;
    clear_n = 1'b0; code_valid = 1'b0; code = '0;

    // reset, acquire and lock
    add(0,0,5'b00000, 0,0,0,0,0,0); add(0,0,5'b00000, 0,0,0,0,0,0);
    add(1,1,5'b00000, 0,1,0,0,0,0); add(1,1,5'b10000, 1,1,0,0,0,0);
    add(1,1,5'b11000, 2,1,0,0,0,0); add(1,1,5'b11100, 3,1,1,0,0,0);
    // run round to the wrap, then idle
    add(1,1,5'b11110, 4,1,1,0,0,0); add(1,1,5'b11111, 5,1,1,0,0,0);
    add(1,1,5'b01111, 6,1,1,0,0,0); add(1,1,5'b00111, 7,1,1,0,0,0);
    add(1,1,5'b00011, 8,1,1,0,0,0); add(1,1,5'b00001, 9,1,1,0,0,0);
    add(1,1,5'b00000, 0,1,1,1,0,0); add(1,0,5'b10101, 0,1,1,0,0,0);
    // illegal code while locked, then reacquire
    add(1,1,5'b10000, 1,1,1,0,0,0); add(1,1,5'b11000, 2,1,1,0,0,0);
    add(1,1,5'b11100, 3,1,1,0,0,0); add(1,1,5'b11011, 3,0,0,0,1,1);
    add(1,1,5'b11110, 4,1,0,0,0,1);
    // relock, then a legal jump while locked
    add(1,1,5'b11111, 5,1,0,0,0,1); add(1,1,5'b01111, 6,1,0,0,0,1);
    add(1,1,5'b00111, 7,1,1,0,0,1); add(1,1,5'b00011, 8,1,1,0,0,1);
    add(1,1,5'b00001, 9,1,1,0,0,1); add(1,1,5'b00000, 0,1,1,1,0,1);
    add(1,1,5'b10000, 1,1,1,0,0,1); add(1,1,5'b11000, 2,1,1,0,0,1);
    add(1,1,5'b00111, 7,1,0,0,1,2);
    // wrap during acquire, relock, hold and idle
    add(1,1,5'b00011, 8,1,0,0,0,2); add(1,1,5'b00001, 9,1,0,0,0,2);
    add(1,1,5'b00000, 0,1,0,1,0,2); add(1,1,5'b10000, 1,1,1,0,0,2);
    add(1,1,5'b11000, 2,1,1,0,0,2); add(1,1,5'b11100, 3,1,1,0,0,2);
    add(1,1,5'b11110, 4,1,1,0,0,2); add(1,1,5'b11110, 4,1,1,0,0,2);
    add(1,1,5'b11110, 4,1,1,0,0,2); add(1,1,5'b11110, 4,1,1,0,0,2);
    add(1,0,5'b01010, 4,1,1,0,0,2); add(1,0,5'b11011, 4,1,1,0,0,2);
    // clear wins over a valid code; hold in acquire must not count
    add(0,1,5'b11111, 0,0,0,0,0,0); add(1,1,5'b00000, 0,1,0,0,0,0);
    add(1,1,5'b00000, 0,1,0,0,0,0); add(1,1,5'b10000, 1,1,0,0,0,0);
    add(1,1,5'b11000, 2,1,0,0,0,0); add(1,1,5'b11100, 3,1,1,0,0,0);
    // illegal code in acquire and in unlocked: no err
    add(0,0,5'b00000, 0,0,0,0,0,0); add(1,1,5'b00000, 0,1,0,0,0,0);
    add(1,1,5'b01010, 0,0,0,0,0,0); add(1,1,5'b01010, 0,0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].clr_n, tbl[i].vld, tbl[i].code);
      chk("tbl_index",       int'(index),       tbl[i].e_idx);
      chk("tbl_index_valid", int'(index_valid), tbl[i].e_iv);
      chk("tbl_locked",      int'(locked),      tbl[i].e_lk);
      chk("tbl_wrap",        int'(wrap),        tbl[i].e_wr);
      chk("tbl_err",         int'(err),         tbl[i].e_er);
      chk("tbl_err_count",   int'(err_count),   tbl[i].e_ec);
    end

    // saturate the error counter: 256 lock-then-break rounds
    step(1'b0, 1'b0, 5'b00000);
    for (int e = 0; e < 256; e++) begin
      step(1, 1, 5'b00000); step(1, 1, 5'b10000);
      step(1, 1, 5'b11000); step(1, 1, 5'b11100);
      step(1, 1, 5'b11011);
      if (e >= 254) begin
        chk("sat_err_count", int'(err_count), 255);
        chk("sat_err_pulse", int'(err), 1);
      end
    end

    // random traffic biased toward legal progress
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      c = seq[(m_idx + 1) % 10];
      else if (r < 6) c = seq[m_idx];
      else if (r < 8) c = seq[$urandom_range(0, 9)];
      else            c = 5'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
